// File: rtl/arp_scheduler.sv
// ARP request/reply scheduler with a single-entry MAC cache and retrying resolution.
// Optional build macro ARP_CACHE_AGING_EN adds a lifetime counter to the cache entry.
module arp_scheduler #(
    parameter logic [31:0] P_RETRY_CYCLES = 32'd125000,
    parameter int          P_MAX_RETRY    = 3,
    parameter logic [31:0] P_AGE_CYCLES   = 32'd625000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_recv_target_mac,
    input  logic [31:0] i_recv_target_ip,
    input  logic        i_recv_target_valid,
    input  logic        i_arp_reply,
    input  logic [31:0] i_lookup_ip,
    input  logic        i_lookup_valid,
    output logic        o_lookup_ready,
    output logic        o_lookup_done,
    output logic        o_lookup_hit,
    output logic [47:0] o_lookup_mac,
    output logic        o_arp_tx_start,
    output logic [15:0] o_arp_tx_op,
    output logic [31:0] o_arp_tx_target_ip,
    output logic [47:0] o_arp_tx_target_mac,
    input  logic        i_arp_tx_done
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] TX_REPLY  = 2'd1;
    localparam logic [1:0] TX_REQ    = 2'd2;
    localparam logic [1:0] WAIT_RESP = 2'd3;

    localparam logic [7:0]  MAX_RETRY   = 8'(P_MAX_RETRY);
    localparam logic [15:0] OP_REQUEST  = 16'd1;
    localparam logic [15:0] OP_REPLY    = 16'd2;

    logic [1:0]  state;
    logic        reply_pending;
    logic        reply_nested;
    logic [31:0] reply_ip;
    logic [47:0] reply_mac;
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;
    logic [31:0] lookup_ip_q;
    logic [7:0]  retry_cnt;
    logic [31:0] wait_timer;

    logic recv_ok;
    logic lookup_fire;
    logic cache_hit;
    logic resp_match;
    logic timer_expired;
    logic timer_running;

    assign recv_ok       = i_recv_target_valid && (i_recv_target_ip != 32'd0);
    assign lookup_fire   = i_lookup_valid && o_lookup_ready;
    assign cache_hit     = cache_valid && (cache_ip == i_lookup_ip);
    assign resp_match    = recv_ok && (i_recv_target_ip == lookup_ip_q);
    assign timer_expired = wait_timer >= (P_RETRY_CYCLES - 32'd1);
    assign timer_running = (state == WAIT_RESP) || ((state == TX_REPLY) && reply_nested);

    // A reply request arriving this cycle already blocks the lookup handshake.
    assign o_lookup_ready = !i_rst && (state == IDLE) && !reply_pending && !i_arp_reply;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reply_ip  <= 32'd0;
            reply_mac <= 48'd0;
            cache_ip  <= 32'd0;
            cache_mac <= 48'd0;
        end else if (recv_ok) begin
            reply_ip  <= i_recv_target_ip;
            reply_mac <= i_recv_target_mac;
            cache_ip  <= i_recv_target_ip;
            cache_mac <= i_recv_target_mac;
        end
    end

`ifdef ARP_CACHE_AGING_EN
    logic [31:0] age_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cache_valid <= 1'b0;
            age_cnt     <= 32'd0;
        end else if (recv_ok) begin
            cache_valid <= 1'b1;
            age_cnt     <= 32'd0;
        end else if (cache_valid) begin
            if (age_cnt >= (P_AGE_CYCLES - 32'd1)) begin
                cache_valid <= 1'b0;
            end else begin
                age_cnt <= age_cnt + 32'd1;
            end
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cache_valid <= 1'b0;
        end else if (recv_ok) begin
            cache_valid <= 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state               <= IDLE;
            reply_pending       <= 1'b0;
            reply_nested        <= 1'b0;
            lookup_ip_q         <= 32'd0;
            retry_cnt           <= 8'd0;
            wait_timer          <= 32'd0;
            o_lookup_done       <= 1'b0;
            o_lookup_hit        <= 1'b0;
            o_lookup_mac        <= 48'd0;
            o_arp_tx_start      <= 1'b0;
            o_arp_tx_op         <= 16'd0;
            o_arp_tx_target_ip  <= 32'd0;
            o_arp_tx_target_mac <= 48'd0;
        end else begin
            o_lookup_done  <= 1'b0;
            o_arp_tx_start <= 1'b0;
            if (i_arp_reply) begin
                reply_pending <= 1'b1;
            end
            // The response timer saturates so a timeout missed during a nested reply still fires.
            if (timer_running && (wait_timer != 32'hFFFF_FFFF)) begin
                wait_timer <= wait_timer + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (reply_pending) begin
                        state               <= TX_REPLY;
                        reply_nested        <= 1'b0;
                        reply_pending       <= 1'b0;
                        o_arp_tx_start      <= 1'b1;
                        o_arp_tx_op         <= OP_REPLY;
                        o_arp_tx_target_ip  <= reply_ip;
                        o_arp_tx_target_mac <= reply_mac;
                    end else if (lookup_fire) begin
                        if (cache_hit) begin
                            o_lookup_done <= 1'b1;
                            o_lookup_hit  <= 1'b1;
                            o_lookup_mac  <= cache_mac;
                        end else begin
                            state               <= TX_REQ;
                            lookup_ip_q         <= i_lookup_ip;
                            retry_cnt           <= 8'd0;
                            o_arp_tx_start      <= 1'b1;
                            o_arp_tx_op         <= OP_REQUEST;
                            o_arp_tx_target_ip  <= i_lookup_ip;
                            o_arp_tx_target_mac <= 48'd0;
                        end
                    end
                end
                TX_REQ: begin
                    if (i_arp_tx_done) begin
                        retry_cnt  <= retry_cnt + 8'd1;
                        wait_timer <= 32'd0;
                        state      <= WAIT_RESP;
                    end
                end
                TX_REPLY: begin
                    if (i_arp_tx_done) begin
                        state <= reply_nested ? WAIT_RESP : IDLE;
                    end
                end
                WAIT_RESP: begin
                    if (resp_match) begin
                        state         <= IDLE;
                        o_lookup_done <= 1'b1;
                        o_lookup_hit  <= 1'b1;
                        o_lookup_mac  <= i_recv_target_mac;
                    end else if (reply_pending) begin
                        state               <= TX_REPLY;
                        reply_nested        <= 1'b1;
                        reply_pending       <= 1'b0;
                        o_arp_tx_start      <= 1'b1;
                        o_arp_tx_op         <= OP_REPLY;
                        o_arp_tx_target_ip  <= reply_ip;
                        o_arp_tx_target_mac <= reply_mac;
                    end else if (timer_expired) begin
                        if (retry_cnt < MAX_RETRY) begin
                            state               <= TX_REQ;
                            o_arp_tx_start      <= 1'b1;
                            o_arp_tx_op         <= OP_REQUEST;
                            o_arp_tx_target_ip  <= lookup_ip_q;
                            o_arp_tx_target_mac <= 48'd0;
                        end else begin
                            state         <= IDLE;
                            o_lookup_done <= 1'b1;
                            o_lookup_hit  <= 1'b0;
                            o_lookup_mac  <= 48'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/arp_scheduler.md
ARP_SCHEDULER -- requirements
Module: arp_scheduler

Interface
REQ-001 P_RETRY_CYCLES, 32'd125000, cycles to wait for an ARP response before re-requesting.
REQ-002 P_MAX_RETRY, 3, ARP requests sent per lookup before failure is reported.
REQ-003 P_AGE_CYCLES, 32'd625000000, cache entry lifetime in cycles; used only when ARP_CACHE_AGING_EN is defined.
REQ-004 i_clk  in  1  clock; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_recv_target_mac  in  48; i_recv_target_ip  in  32; i_recv_target_valid  in  1  one-cycle pulse carrying the sender MAC/IP learned from a received ARP packet.
REQ-006 i_arp_reply  in  1  one-cycle pulse: a request for the local IP was received and a reply is required.
REQ-007 i_lookup_ip  in  32; i_lookup_valid  in  1; o_lookup_ready  out  1  IP-layer MAC resolution request, valid/ready handshake.
REQ-008 o_lookup_done  out  1  pulse; o_lookup_hit  out  1; o_lookup_mac  out  48  resolution result, qualified by o_lookup_done.
REQ-009 o_arp_tx_start  out  1  pulse; o_arp_tx_op  out  16  (1 request, 2 reply); o_arp_tx_target_ip  out  32; o_arp_tx_target_mac  out  48; i_arp_tx_done  in  1  pulse when the ARP TX packet has been sent.

Function
REQ-010 FSM states IDLE, TX_REPLY, TX_REQ, WAIT_RESP; one state register.
REQ-011 On i_recv_target_valid, the block latches the MAC/IP into reply registers and writes them into a single-entry cache (valid=1); IP 0 is ignored.
REQ-012 i_arp_reply sets reply_pending; reply_pending clears on entry to TX_REPLY; a second i_arp_reply while pending is absorbed.
REQ-013 o_lookup_ready = 1 only in IDLE with reply_pending = 0.
REQ-014 On an accepted lookup whose IP matches the cache (valid), the block pulses o_lookup_done with hit=1 and the cached MAC on the next cycle; it stays in IDLE and sends nothing.
REQ-015 On an accepted lookup that misses, the block latches the IP, sets retry_cnt = 0 and enters TX_REQ.
REQ-016 Same-cycle cache write and lookup: the compare uses the pre-write cache contents.
REQ-017 IDLE priority: reply_pending -> TX_REPLY; otherwise the lookup handshake.
REQ-018 On entering TX_REPLY/TX_REQ, o_arp_tx_start pulses 1 cycle; op/ip/mac stay stable until i_arp_tx_done.
REQ-019 TX_REPLY drives op=2 with the latched requester IP/MAC; TX_REQ drives op=1, the lookup IP and MAC 48'h0.
REQ-020 i_arp_tx_done in TX_REQ: retry_cnt+1, wait timer cleared, go to WAIT_RESP.
REQ-021 i_arp_tx_done in TX_REPLY: return to WAIT_RESP if entered from there, else IDLE.
REQ-022 WAIT_RESP: the timer counts every cycle, including during a nested TX_REPLY.
REQ-023 WAIT_RESP: i_recv_target_valid with IP equal to the lookup IP -> o_lookup_done, hit=1, received MAC, go to IDLE; this takes precedence over timeout in the same cycle.
REQ-024 WAIT_RESP: reply_pending -> TX_REPLY (nested).
REQ-025 Timer reaches P_RETRY_CYCLES-1: if retry_cnt < P_MAX_RETRY go to TX_REQ, else o_lookup_done with hit=0 and MAC 0, go to IDLE.
REQ-026 The timer is 32 bits, saturating; retry_cnt is 8 bits.

Reset
REQ-027 All outputs 0, the cache invalid, the reply registers, reply_pending, timer and retry_cnt 0, and the state IDLE.
REQ-028 Reset mid-operation aborts the operation with no o_lookup_done pulse.

Configuration
REQ-029 With ARP_CACHE_AGING_EN defined, an age counter clears on each cache write and invalidates the entry at P_AGE_CYCLES; on a same-cycle age expiry and write, the write wins.
REQ-030 With ARP_CACHE_AGING_EN undefined, there is no age counter and the entry stays valid until reset.

Verification
REQ-031 recv_valid IP C0A86401 / MAC 112233445566, then lookup C0A86401 -> next-cycle done, hit=1, MAC 112233445566, no tx_start.
REQ-032 Lookup C0A86405 on an empty cache -> tx_start op=1 ip C0A86405 mac 0; after tx_done, recv_valid for that IP -> done hit=1.
REQ-033 P_RETRY_CYCLES=100, P_MAX_RETRY=3, no response -> 3 tx_starts about 100 cycles apart, then done hit=0.
REQ-034 i_arp_reply during WAIT_RESP -> tx_start op=2 with the latched requester; the timer keeps running and the original timeout still occurs.
REQ-035 i_arp_reply and lookup_valid in the same IDLE cycle -> ready=0, reply sent first, lookup accepted after tx_done.
REQ-036 ARP_CACHE_AGING_EN with P_AGE_CYCLES=50: a lookup 60 cycles after a cache write misses and sends a request.
